logic_sweep_ctrl: RTL

Self-checking sequencer for small combinational logic units such as the three-input AND/OR gate network (`X`, `AB`, `AC`). It drives every input combination onto the unit in ascending order and waits a programmable settle time per vector. It samples the unit's outputs, compares them against a golden truth table, and reports a pass/fail summary. It sits between a simple start/abort command interface and the device under test, replacing hand-written `#10` stimulus with a clocked, repeatable sweep.

---
 rtl/logic_sweep_pkg.sv | 19 +
 rtl/logic_sweep_cnt.sv | 55 +++++
 rtl/logic_sweep_ctrl.sv | 152 +++++++++++++++
 3 files changed

// File: rtl/logic_sweep_pkg.sv
// Shared types and defaults for the logic sweep sequencer.
// The default golden table models {X, AB, AC} of the three-input AND/OR network.
package logic_sweep_pkg;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_DRIVE  = 2'd1,
    S_SAMPLE = 2'd2,
    S_DONE   = 2'd3
  } state_t;

  localparam int unsigned N_IN_DEF   = 3;
  localparam int unsigned N_OUT_DEF  = 3;
  localparam int unsigned SETTLE_DEF = 2;
  localparam int unsigned WAIT_W     = 4;

  localparam logic [23:0] EXPECT_GATES = 24'hFA8000;

endpackage

// File: rtl/logic_sweep_cnt.sv
// Settle-wait and vector-index counter pair with terminal-count flags.
// idx_next exposes the index the counter will hold after the coming edge.
module logic_sweep_cnt
  import logic_sweep_pkg::*;
#(
  parameter int unsigned N_IN   = N_IN_DEF,
  parameter int unsigned SETTLE = SETTLE_DEF
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            clr,
  input  logic            wait_step,
  input  logic            vec_step,
  output logic [N_IN-1:0] idx,
  output logic [N_IN-1:0] idx_next,
  output logic            wait_tc,
  output logic            idx_tc
);

  localparam logic [WAIT_W-1:0] WAIT_LAST = (SETTLE == 0) ? '0 : WAIT_W'(SETTLE - 1);
  localparam logic [N_IN-1:0]   IDX_LAST  = '1;

  logic [WAIT_W-1:0] wait_q, wait_d;
  logic [N_IN-1:0]   idx_q, idx_d;

  assign wait_tc  = (wait_q == WAIT_LAST);
  assign idx_tc   = (idx_q == IDX_LAST);
  assign idx      = idx_q;
  assign idx_next = idx_d;

  always_comb begin
    wait_d = wait_q;
    idx_d  = idx_q;
    if (clr) begin
      wait_d = '0;
      idx_d  = '0;
    end else if (vec_step) begin
      wait_d = '0;
      idx_d  = idx_q + 1'b1;
    end else if (wait_step) begin
      wait_d = wait_tc ? '0 : wait_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wait_q <= '0;
      idx_q  <= '0;
    end else begin
      wait_q <= wait_d;
      idx_q  <= idx_d;
    end
  end

endmodule

// File: rtl/logic_sweep_ctrl.sv
// Sweeps every input vector onto a combinational unit, compares its outputs
// against a packed golden table and reports pass / fail count / first failure.
module logic_sweep_ctrl
  import logic_sweep_pkg::*;
#(
  parameter int unsigned                    N_IN   = N_IN_DEF,
  parameter int unsigned                    N_OUT  = N_OUT_DEF,
  parameter int unsigned                    SETTLE = SETTLE_DEF,
  parameter logic [(1<<N_IN)*N_OUT-1:0]     EXPECT = EXPECT_GATES
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             abort,
  output logic [N_IN-1:0]  stim,
  input  logic [N_OUT-1:0] resp,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [N_IN:0]    fail_count,
  output logic [N_IN-1:0]  first_fail
);

  // With no settle time every vector lives entirely in SAMPLE.
  localparam state_t        S_VEC    = (SETTLE == 0) ? S_SAMPLE : S_DRIVE;
  localparam logic [N_IN:0] FAIL_MAX = {1'b1, {N_IN{1'b0}}};

  state_t state_q, state_d;

  logic [N_IN-1:0] stim_q, stim_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic            pass_q, pass_d;
  logic [N_IN:0]   fail_q, fail_d;
  logic [N_IN-1:0] ff_q, ff_d;

  logic            cnt_clr, wait_step, vec_step;
  logic [N_IN-1:0] idx, idx_next;
  logic            wait_tc, idx_tc;
  logic [N_OUT-1:0] golden;
  logic            mismatch;

  logic_sweep_cnt #(
    .N_IN   (N_IN),
    .SETTLE (SETTLE)
  ) u_cnt (
    .clk       (clk),
    .rst_n     (rst_n),
    .clr       (cnt_clr),
    .wait_step (wait_step),
    .vec_step  (vec_step),
    .idx       (idx),
    .idx_next  (idx_next),
    .wait_tc   (wait_tc),
    .idx_tc    (idx_tc)
  );

  assign golden   = EXPECT[idx*N_OUT +: N_OUT];
  assign mismatch = (resp != golden);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:   if (start) state_d = S_VEC;
      S_DRIVE: begin
        if (abort)        state_d = S_IDLE;
        else if (wait_tc) state_d = S_SAMPLE;
      end
      S_SAMPLE: begin
        if (abort)       state_d = S_IDLE;
        else if (idx_tc) state_d = S_DONE;
        else             state_d = S_VEC;
      end
      S_DONE:   state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // Outputs are computed from the next state so every port comes from a flop.
  always_comb begin
    cnt_clr   = 1'b0;
    wait_step = 1'b0;
    vec_step  = 1'b0;
    fail_d    = fail_q;
    ff_d      = ff_q;
    pass_d    = pass_q;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          cnt_clr = 1'b1;
          fail_d  = '0;
          ff_d    = '0;
          pass_d  = 1'b0;
        end
      end
      S_DRIVE: begin
        if (abort) pass_d = 1'b0;
        else       wait_step = 1'b1;
      end
      S_SAMPLE: begin
        if (abort) begin
          pass_d = 1'b0;
        end else begin
          if (mismatch) begin
            if (fail_q != FAIL_MAX) fail_d = fail_q + 1'b1;
            if (fail_q == '0)       ff_d   = idx;
          end
          if (idx_tc) pass_d   = (fail_d == '0);
          else        vec_step = 1'b1;
        end
      end
      default: ;
    endcase
    stim_d = (state_d == S_DRIVE || state_d == S_SAMPLE) ? idx_next : '0;
    busy_d = (state_d != S_IDLE);
    done_d = (state_d == S_DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stim_q <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      pass_q <= 1'b0;
      fail_q <= '0;
      ff_q   <= '0;
    end else begin
      stim_q <= stim_d;
      busy_q <= busy_d;
      done_q <= done_d;
      pass_q <= pass_d;
      fail_q <= fail_d;
      ff_q   <= ff_d;
    end
  end

  assign stim       = stim_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign pass       = pass_q;
  assign fail_count = fail_q;
  assign first_fail = ff_q;

endmodule
